// File: rtl/serial_alu_pkg.sv
// Shared types and ALU control encodings for the bit-serial ALU sequencer.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SLTFIX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Start/done request bus between a datapath controller and the serial ALU.
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, alu_op, a, b,
        input  busy, done, result, zero, carry_out, overflow
    );

    modport slave (
        input  start, alu_op, a, b,
        output busy, done, result, zero, carry_out, overflow
    );
endinterface

// File: rtl/serial_alu_slice.sv
// Combinational one-bit MIPS ALU slice: invert muxes, full adder, 4:1 result mux.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_a_invert,
    input  logic       i_b_invert,
    input  logic       i_carry_in,
    input  logic       i_less,
    input  logic [1:0] i_op,
    output logic       o_result,
    output logic       o_carry_out,
    output logic       o_sum
);

    logic w_a;
    logic w_b;

    assign w_a         = i_a ^ i_a_invert;
    assign w_b         = i_b ^ i_b_invert;
    assign o_sum       = w_a ^ w_b ^ i_carry_in;
    assign o_carry_out = (w_a & w_b) | (w_a & i_carry_in) | (w_b & i_carry_in);

    always_comb begin
        o_result = 1'b0;
        case (i_op)
            OP_AND:  o_result = w_a & w_b;
            OP_OR:   o_result = w_a | w_b;
            OP_SUM:  o_result = o_sum;
            OP_LESS: o_result = i_less;
            default: o_result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: one slice reused across WIDTH bits, LSB first.
// Define SERIAL_ALU_SLT_EN to enable set-on-less-than (extra SLTFIX cycle).
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_alu_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_ctl;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;
`ifdef SERIAL_ALU_SLT_EN
    logic             r_sum_msb;
    logic             w_slt_bit;
`endif

    logic             w_res_bit;
    logic             w_cout;
    logic             w_sum;
    logic             w_last;
    logic [WIDTH-1:0] w_shifted;

    serial_alu_slice u_slice (
        .i_a         (r_a[0]),
        .i_b         (r_b[0]),
        .i_a_invert  (r_ctl[3]),
        .i_b_invert  (r_ctl[2]),
        .i_carry_in  (r_carry),
        .i_less      (1'b0),
        .i_op        (r_ctl[1:0]),
        .o_result    (w_res_bit),
        .o_carry_out (w_cout),
        .o_sum       (w_sum)
    );

    assign w_last    = (r_state == S_RUN) && (r_cnt == '0);
    assign w_shifted = {w_res_bit, r_result[WIDTH-1:1]};
`ifdef SERIAL_ALU_SLT_EN
    assign w_slt_bit = r_sum_msb ^ r_ovf;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next_state = S_RUN;
            S_RUN: begin
                if (w_last) begin
`ifdef SERIAL_ALU_SLT_EN
                    w_next_state = (r_ctl[1:0] == OP_LESS) ? S_SLTFIX : S_DONE;
`else
                    w_next_state = S_DONE;
`endif
                end
            end
            S_SLTFIX: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Operands shift right so the slice always sees bit 0; r_cnt counts down to the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_ctl     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
`ifdef SERIAL_ALU_SLT_EN
            r_sum_msb <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_ctl   <= bus.alu_op;
                        r_carry <= bus.alu_op[2];
                        r_cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_carry  <= w_cout;
                    r_result <= w_shifted;
                    r_cnt    <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_cout    <= w_cout;
                        r_ovf     <= r_carry ^ w_cout;
                        r_zero    <= (w_shifted == '0);
`ifdef SERIAL_ALU_SLT_EN
                        r_sum_msb <= w_sum;
`endif
                    end
                end
`ifdef SERIAL_ALU_SLT_EN
                S_SLTFIX: begin
                    r_result[0] <= w_slt_bit;
                    r_zero      <= (r_result[WIDTH-1:1] == '0) && !w_slt_bit;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state == S_RUN) || (r_state == S_SLTFIX);
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry_out = r_cout;
    assign bus.overflow  = r_ovf;

endmodule
